axis_frame_trailer: RTL and testbench

AXI4-Stream stage between the loopback stage's master port and the DMA S2MM slave port. It forwards every data beat of a frame unchanged, and clears TLAST on the final data beat. After the frame it appends one trailer beat carrying the beat count and a 16-bit XOR checksum, and asserts TLAST on that trailer. Software reads the trailer to confirm that the DMA round trip delivered every beat intact.

---
 rtl/axis_frame_trailer_if.sv | 17 +
 rtl/axis_frame_trailer.sv | 198 +++++++++++++++++++
 tb/tb_axis_frame_trailer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_trailer_if.sv
// axis_frame_trailer_if
//   AXI4-Stream bundle (valid/data/last/ready) for axis_frame_trailer.
//   Parameter: DATA_WIDTH - width of the data bus.
//   Modports:
//     master - drives valid/data/last, receives ready
//     slave  - receives valid/data/last, drives ready
interface axis_frame_trailer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_frame_trailer.sv
// axis_frame_trailer
//   AXI4-Stream stage that forwards every data beat of a frame with TLAST
//   cleared, then appends one trailer beat {beat_cnt, xor16 checksum} with
//   TLAST set. Software compares the trailer against what it sent to verify
//   a DMA round trip.
//
// Parameters:
//   DATA_WIDTH - stream width (>= 32, multiple of 16)
//   MAX_BEATS  - frame length limit (1..65535), only used with ERR_TRUNC_EN
//
// Ports:
//   axi_clk      - clock, rising edge
//   axi_reset    - asynchronous active-high reset
//   s_axis       - upstream stream (slave modport); ready is combinational
//   m_axis       - downstream stream (master modport); valid/data/last
//                  come from a single-entry output register
//   frame_count  - trailers delivered, wraps at 16 bits
//   err_truncate - sticky truncation flag
//
// Build option:
//   ERR_TRUNC_EN - when defined, frames longer than MAX_BEATS are cut at
//                  MAX_BEATS beats, the rest of the input frame is dropped
//                  and err_truncate is set. Undefined: no length limit and
//                  err_truncate stays 0.
module axis_frame_trailer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 1024
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset,
  axis_frame_trailer_if.slave  s_axis,
  axis_frame_trailer_if.master m_axis,
  output logic [15:0]          frame_count,
  output logic                 err_truncate
);

  localparam int LANES = DATA_WIDTH / 16;

`ifdef ERR_TRUNC_EN
  localparam logic [15:0] MAX_CNT = 16'(MAX_BEATS);
  typedef enum logic [1:0] {ST_PASS, ST_TRAILER, ST_TRL_OUT, ST_DROP} state_t;
`else
  typedef enum logic [1:0] {ST_PASS, ST_TRAILER, ST_TRL_OUT} state_t;
  logic unused_cfg;
  assign unused_cfg = (MAX_BEATS > 0);
`endif

  state_t                state_reg, state_next;
  logic                  m_valid_reg, m_valid_next;
  logic [DATA_WIDTH-1:0] m_data_reg, m_data_next;
  logic                  m_last_reg, m_last_next;
  logic [15:0]           beat_cnt_reg, beat_cnt_next;
  logic [15:0]           csum_reg, csum_next;
  logic                  drop_pending_reg, drop_pending_next;
  logic [15:0]           frame_count_reg, frame_count_next;
  logic                  err_truncate_reg, err_truncate_next;

  logic        load_ok;
  logic        s_ready;
  logic        accept;
  logic        take_beat;
  logic [15:0] lane_xor;
  logic [15:0] base_cnt;
  logic [15:0] base_csum;
  logic [15:0] cnt_inc;

  // XOR of all 16-bit lanes of the incoming beat.
  always_comb begin
    lane_xor = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_xor = lane_xor ^ s_axis.data[i*16 +: 16];
    end
  end

  // Output register can take a new value when empty or being drained.
  assign load_ok = !m_valid_reg || m_axis.ready;

  always_comb begin
    s_ready = 1'b0;
    case (state_reg)
      ST_PASS:    s_ready = load_ok;
      ST_TRAILER: s_ready = 1'b0;
      // A beat here loads into the register the trailer is leaving, but
      // never while the rest of a truncated frame still has to be dropped.
      ST_TRL_OUT: s_ready = m_axis.ready && !drop_pending_reg;
`ifdef ERR_TRUNC_EN
      ST_DROP:    s_ready = 1'b1;
`endif
      default:    s_ready = 1'b0;
    endcase
  end

  assign accept    = s_axis.valid && s_ready;
  assign take_beat = accept && (state_reg == ST_PASS || state_reg == ST_TRL_OUT);

  always_comb begin
    state_next        = state_reg;
    m_valid_next      = m_valid_reg && !m_axis.ready;
    m_data_next       = m_data_reg;
    m_last_next       = m_last_reg;
    beat_cnt_next     = beat_cnt_reg;
    csum_next         = csum_reg;
    drop_pending_next = drop_pending_reg;
    frame_count_next  = frame_count_reg;
    err_truncate_next = err_truncate_reg;
    base_cnt          = beat_cnt_reg;
    base_csum         = csum_reg;
    cnt_inc           = '0;

    case (state_reg)
      ST_TRAILER: begin
        if (load_ok) begin
          m_valid_next       = 1'b1;
          m_data_next        = '0;
          m_data_next[31:0]  = {beat_cnt_reg, csum_reg};
          m_last_next        = 1'b1;
          state_next         = ST_TRL_OUT;
        end
      end
      ST_TRL_OUT: begin
        if (m_axis.ready) begin
          frame_count_next = frame_count_reg + 16'd1;
          beat_cnt_next    = '0;
          csum_next        = '0;
          // A beat taken this same cycle starts from cleared accumulators.
          base_cnt         = '0;
          base_csum        = '0;
`ifdef ERR_TRUNC_EN
          state_next       = drop_pending_reg ? ST_DROP : ST_PASS;
`else
          state_next       = ST_PASS;
`endif
        end
      end
`ifdef ERR_TRUNC_EN
      ST_DROP: begin
        if (accept && s_axis.last) begin
          drop_pending_next = 1'b0;
          state_next        = ST_PASS;
        end
      end
`endif
      default: ;
    endcase

    if (take_beat) begin
      cnt_inc       = (base_cnt == 16'hFFFF) ? base_cnt : base_cnt + 16'd1;
      m_valid_next  = 1'b1;
      m_data_next   = s_axis.data;
      m_last_next   = 1'b0;
      beat_cnt_next = cnt_inc;
      csum_next     = base_csum ^ lane_xor;
      if (s_axis.last) begin
        state_next = ST_TRAILER;
      end
`ifdef ERR_TRUNC_EN
      else if (cnt_inc == MAX_CNT) begin
        // Close the frame here; the remainder is discarded in ST_DROP.
        err_truncate_next = 1'b1;
        drop_pending_next = 1'b1;
        state_next        = ST_TRAILER;
      end
`endif
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_reg        <= ST_PASS;
      m_valid_reg      <= 1'b0;
      m_data_reg       <= '0;
      m_last_reg       <= 1'b0;
      beat_cnt_reg     <= '0;
      csum_reg         <= '0;
      drop_pending_reg <= 1'b0;
      frame_count_reg  <= '0;
      err_truncate_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      m_valid_reg      <= m_valid_next;
      m_data_reg       <= m_data_next;
      m_last_reg       <= m_last_next;
      beat_cnt_reg     <= beat_cnt_next;
      csum_reg         <= csum_next;
      drop_pending_reg <= drop_pending_next;
      frame_count_reg  <= frame_count_next;
      err_truncate_reg <= err_truncate_next;
    end
  end

  assign s_axis.ready = s_ready;
  assign m_axis.valid = m_valid_reg;
  assign m_axis.data  = m_data_reg;
  assign m_axis.last  = m_last_reg;
  assign frame_count  = frame_count_reg;
  assign err_truncate = err_truncate_reg;

endmodule

// File: tb/tb_axis_frame_trailer.sv
// tb_axis_frame_trailer
//   Self-checking bench for axis_frame_trailer. Expected output beats are
//   built per frame from the frame contents (beat list -> data beats plus
//   {count, xor16} trailer) and compared against every output handshake.
//   Build option ERR_TRUNC_EN selects MAX_BEATS=4 and truncation checks.
module tb_axis_frame_trailer;

  localparam int DW = 32;
`ifdef ERR_TRUNC_EN
  localparam int MAXB = 4;
`else
  localparam int MAXB = 1024;
`endif

  logic        axi_clk = 1'b0;
  logic        axi_reset = 1'b0;
  logic [15:0] frame_count;
  logic        err_truncate;

  axis_frame_trailer_if #(.DATA_WIDTH(DW)) s_if ();
  axis_frame_trailer_if #(.DATA_WIDTH(DW)) m_if ();

  axis_frame_trailer #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .frame_count  (frame_count),
    .err_truncate (err_truncate)
  );

  always #5 axi_clk = ~axi_clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] exp_q[$];
  logic [31:0] frame_q[$];
  int          exp_frames = 0;
  logic        exp_err = 1'b0;
  bit          rnd_mode = 1'b0;
  bit          mon_en = 1'b1;
  bit          stuck = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  bit          trl_at_acc = 1'b0;
  int          waits = 0;
  int          first_waits = 0;
  bit          first_trl = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called once per cycle, #1 after the falling edge.
  task automatic monitor();
    logic [32:0] e;
    if (!mon_en) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("hold_valid", 64'(m_if.valid), 64'(1));
      chk("hold_data", 64'(m_if.data), 64'(prev_data));
      chk("hold_last", 64'(m_if.last), 64'(prev_last));
    end
    if (m_if.valid && m_if.ready) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat observed=0x%0h expected=none", m_if.data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_beat", 64'({m_if.last, m_if.data}), 64'(e));
      end
    end
    prev_stall = m_if.valid && !m_if.ready;
    prev_data  = m_if.data;
    prev_last  = m_if.last;
  endtask

  task automatic cycle(output bit acc);
    if (rnd_mode) m_if.ready = ($urandom_range(0, 3) != 0);
    #1;
    acc        = s_if.valid && s_if.ready;
    trl_at_acc = m_if.valid && m_if.last && m_if.ready;
    monitor();
    @(posedge axi_clk);
    @(negedge axi_clk);
  endtask

  // Reference: a frame of L beats yields min(L, limit) data beats followed by
  // a trailer {count, xor of all 16-bit halves of the kept beats}.
  task automatic expect_frame();
    int          keep;
    logic [15:0] x;
    keep = frame_q.size();
    x    = '0;
`ifdef ERR_TRUNC_EN
    if (keep > MAXB) begin
      keep    = MAXB;
      exp_err = 1'b1;
    end
`endif
    for (int i = 0; i < keep; i++) begin
      exp_q.push_back({1'b0, frame_q[i]});
      x = x ^ frame_q[i][15:0] ^ frame_q[i][31:16];
    end
    exp_q.push_back({1'b1, ((keep > 65535) ? 16'hFFFF : 16'(keep)), x});
    exp_frames++;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit acc;
    int n;
    if (stuck) return;
    acc   = 1'b0;
    n     = 0;
    waits = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    while (!acc && n < 1000) begin
      cycle(acc);
      if (!acc) waits++;
      n++;
    end
    chk("accept_in_budget", 64'(acc), 64'(1));
    if (!acc) stuck = 1'b1;
  endtask

  task automatic send_frame();
    expect_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      send_beat(frame_q[i], (i == frame_q.size() - 1));
      if (i == 0) begin
        first_waits = waits;
        first_trl   = trl_at_acc;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    while (exp_q.size() != 0 && n < 5000) begin
      cycle(a);
      n++;
    end
    cycle(a);
    cycle(a);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("frame_count", 64'(frame_count), 64'(exp_frames[15:0]));
    chk("err_truncate", 64'(err_truncate), 64'(exp_err));
  endtask

  // Asserts reset at a falling edge, checks outputs clear at once, releases.
  task automatic do_reset();
    axi_reset  = 1'b1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_if.valid), 64'(0));
    chk("rst_m_data", 64'(m_if.data), 64'(0));
    chk("rst_m_last", 64'(m_if.last), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_err_truncate", 64'(err_truncate), 64'(0));
    chk("rst_s_ready", 64'(s_if.ready), 64'(1));
    @(negedge axi_clk);
    axi_reset  = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_err    = 1'b0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.last  = 1'b0;
    m_if.ready = 1'b1;

    @(negedge axi_clk);
    do_reset();

    // Two-beat frame, cycle-exact with m_axis_ready held high.
    s_if.valid = 1'b1; s_if.data = 32'h00010002; s_if.last = 1'b0; #1;
    chk("tb2_s_ready_b0", 64'(s_if.ready), 64'(1));
    @(negedge axi_clk);
    s_if.data = 32'h00030004; s_if.last = 1'b1; #1;
    chk("tb2_out0_data", 64'(m_if.data), 64'(32'h00010002));
    chk("tb2_out0_last", 64'(m_if.last), 64'(0));
    chk("tb2_s_ready_b1", 64'(s_if.ready), 64'(1));
    @(negedge axi_clk);
    s_if.valid = 1'b0; s_if.last = 1'b0; #1;
    chk("tb2_out1_data", 64'(m_if.data), 64'(32'h00030004));
    chk("tb2_out1_last", 64'(m_if.last), 64'(0));
    chk("tb2_s_ready_trailer", 64'(s_if.ready), 64'(0));
    @(negedge axi_clk); #1;
    chk("tb2_trl_valid", 64'(m_if.valid), 64'(1));
    chk("tb2_trl_data", 64'(m_if.data), 64'(32'h00020004));
    chk("tb2_trl_last", 64'(m_if.last), 64'(1));
    chk("tb2_s_ready_trl_out", 64'(s_if.ready), 64'(1));
    chk("tb2_frame_count_before", 64'(frame_count), 64'(0));
    @(negedge axi_clk); #1;
    chk("tb2_frame_count_after", 64'(frame_count), 64'(1));
    chk("tb2_valid_after", 64'(m_if.valid), 64'(0));
    @(negedge axi_clk);
    exp_frames = 1;
    prev_stall = 1'b0;

    // Single-beat frame.
    frame_q.delete();
    frame_q.push_back(32'hDEADBEEF);
    send_frame();
    drain();

    // Reset in the middle of a 4-beat frame, then a fresh frame.
    mon_en = 1'b0;
    send_beat(32'h11112222, 1'b0);
    send_beat(32'h33334444, 1'b0);
    do_reset();
    mon_en = 1'b1;
    frame_q.delete();
    frame_q.push_back(32'h00010002);
    frame_q.push_back(32'h00030004);
    send_frame();
    drain();

    // Back-to-back frames with valid held high across the boundary.
    for (int f = 0; f < 3; f++) begin
      frame_q.delete();
      for (int b = 0; b < 3; b++) frame_q.push_back($urandom);
      send_frame();
      if (f > 0) begin
        chk("b2b_first_wait", 64'(first_waits), 64'(1));
        chk("b2b_overlap_trailer", 64'(first_trl), 64'(1));
      end
    end
    drain();

`ifdef ERR_TRUNC_EN
    // Six beats against a limit of four, then a normal frame.
    frame_q.delete();
    for (int b = 0; b < 6; b++) frame_q.push_back(32'h00000001);
    send_frame();
    drain();
    frame_q.delete();
    frame_q.push_back(32'hCAFE0001);
    frame_q.push_back(32'h0BAD0002);
    send_frame();
    drain();
`endif

    // 100 random frames under random backpressure.
    @(negedge axi_clk);
    do_reset();
    rnd_mode = 1'b1;
    for (int f = 0; f < 100; f++) begin
      frame_q.delete();
      for (int b = 0; b < int'($urandom_range(1, 64)); b++) frame_q.push_back($urandom);
      send_frame();
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();
    chk("rand_frame_total", 64'(exp_frames), 64'(frame_count));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
